rtl_signal_inject: RTL and testbench
====================================

Name: rtl_signal_inject

Overview:
Debug-side signal override block, the drive-direction counterpart of the signal tap.
- Sits inline between functional RTL and its consumers.
- Passes probe-group signals through unchanged until armed.
- On trigger, after a programmable delay, overrides masked bits of one 32-bit group with host-supplied values for a programmable hold time, then releases.

Parameters:
WIDTH, 128, total pass-through width; must equal 32*GROUPS
GROUPS, 4, number of 32-bit injectable groups
CNT_W, 16, width of delay/hold counters and injection counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
func_in  in  WIDTH  functional signal values from RTL
inject_out  out  WIDTH  func_in with override applied
group_sel  in  8  target group; only [1:0] decoded
inj_mask  in  32  bits to override (1 = override)
inj_value  in  32  override values
delay_cycles  in  CNT_W  cycles from trigger to drive start
hold_cycles  in  CNT_W  drive duration in cycles; 0 = sticky until abort
trig_en  in  1  1 = wait for trig_in; 0 = start on arm
trig_in  in  1  external trigger (e.g. signal tap "triggered")
cmd_arm  in  1  single-cycle arm strobe
cmd_abort  in  1  single-cycle abort strobe
state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 DELAY, 3 DRIVE
active  out  1  high while in DRIVE
done  out  1  one-cycle pulse on release from DRIVE (hold expiry or abort)
inject_count  out  CNT_W  count of DRIVE entries, saturating

Behaviour:
- Reset values: state=IDLE, active=0, done=0, inject_count=0, all latched config=0. inject_out equals func_in during and after reset.
- inject_out is combinational from func_in, with zero latency. Override data comes from registers latched at arm.
- Per bit in latched group g, when active=1: out = mask ? value : func_in. All other bits and all other groups pass through.
- cmd_arm in IDLE:
  - Latches group_sel[1:0], inj_mask, inj_value, delay_cycles, hold_cycles, trig_en.
  - Next state is ARMED.
  - Later changes to the config inputs have no effect until re-arm.
- cmd_arm outside IDLE is ignored.
- ARMED: exits when trig_in=1 or latched trig_en=0, sampled each clock.
  - delay=0: next state is DRIVE.
  - Otherwise: next state is DELAY with the counter loaded to delay-1.
- Timing: arm at edge N with trig_en=0 and delay=0 gives ARMED at N+1 and DRIVE at N+2.
- DELAY: counter decrements each clock; at 0, next state is DRIVE.
- On DRIVE entry:
  - inject_count increments, saturating at all-ones.
  - hold counter loads hold-1.
- DRIVE with hold>0: exactly hold_cycles cycles of active=1, then IDLE with done=1 for one cycle.
- DRIVE with hold=0: stays in DRIVE until cmd_abort.
- cmd_abort in any state: next state is IDLE.
  - done pulses only if aborted from DRIVE.
  - Abort has priority over arm and trigger in the same cycle.
- trig_in is level-sampled. Already-high trig_in at arm fires on the first ARMED cycle.
- inj_mask=0: the sequence runs normally (counters, done, count) with no visible override.
- Asynchronous reset mid-DRIVE: override releases immediately; no done pulse.
- Counters are unsigned CNT_W wide, with no wrap in DELAY/DRIVE (load then count down to 0).

Optional Feature:
RTL_INJECT_XOR_EN
- Defined: adds input port inj_xor_mode (1 bit), latched at arm. When the latched value is 1, masked bits are func_in ^ value (glitch/invert injection) instead of replacement.
- Undefined: port absent; replace mode only.

Decomposition:
- Shared package rtl_debug_pkg holds:
  - FSM state encodings (IDLE/ARMED/DELAY/DRIVE)
  - GROUP_W=32
  - the group-to-bit-range map shared with the signal tap
- One sub-module is natural: rtl_inject_mux, the combinational per-group masked override/xor of WIDTH bits.
- FSM and counters stay in the top module.

Test Plan:
- No arm, func_in=random over 100 cycles -> inject_out==func_in every cycle; state=0; inject_count=0.
- group_sel=1, mask=0x0000FFFF, value=0x0000A5A5, trig_en=0, delay=0, hold=4, arm at cycle 10:
  - cycles 12-15: inject_out[47:32]=0xA5A5, all other bits pass.
  - cycle 16: done=1, state=0, inject_count=1.
- trig_en=1, delay=3, hold=2, trig_in pulsed 20 cycles after arm -> DRIVE starts 4 cycles after the trig_in edge, lasts 2 cycles.
- hold=0 sticky on group 3, mask=0xFF000000, value=0x5A000000 -> override persists 1000 cycles; cmd_abort releases it the next cycle with done=1. Abort and arm asserted together in IDLE -> stays IDLE.
- Assert rst_n=0 mid-DRIVE -> inject_out==func_in immediately; state=0, inject_count=0, no done. cmd_arm while in DELAY -> ignored; latched config unchanged.
- With RTL_INJECT_XOR_EN defined: xor_mode=1, group 0, mask=0xF, value=0xF, func_in[3:0]=0x6 -> inject_out[3:0]=0x9 during DRIVE.

Source files
------------

// File: rtl/rtl_debug_pkg.sv
// Shared debug-block definitions: FSM encodings, group width and
// the group-to-bit-range map used by both the signal tap and the injector.
package rtl_debug_pkg;

    localparam int GROUP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_DRIVE = 2'd3
    } inj_state_e;

    function automatic int grp_lsb(input int g);
        return g * GROUP_W;
    endfunction

endpackage

// File: rtl/rtl_inject_mux.sv
// Combinational per-group override: masked replace (or xor) of one
// 32-bit group; every other bit passes straight through.
module rtl_inject_mux
    import rtl_debug_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int GROUPS = 4
) (
    input  logic [WIDTH-1:0]   func_in,
    input  logic               active,
    input  logic [1:0]         grp,
    input  logic [GROUP_W-1:0] mask,
    input  logic [GROUP_W-1:0] value,
    input  logic               xor_mode,
    output logic [WIDTH-1:0]   data_out
);

    // Zero-latency pass-through with override on the selected group
    always_comb begin
        data_out = func_in;
        for (int g = 0; g < GROUPS; g++) begin
            if (active && (int'(grp) == g)) begin
                if (xor_mode)
                    data_out[grp_lsb(g) +: GROUP_W] =
                        func_in[grp_lsb(g) +: GROUP_W] ^ (value & mask);
                else
                    data_out[grp_lsb(g) +: GROUP_W] =
                        (func_in[grp_lsb(g) +: GROUP_W] & ~mask) |
                        (value & mask);
            end
        end
    end

endmodule

// File: rtl/rtl_signal_inject.sv
// Debug signal override: arm, wait for trigger, delay, drive masked bits.
// Optional RTL_INJECT_XOR_EN adds inj_xor_mode (xor instead of replace).
module rtl_signal_inject
    import rtl_debug_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int GROUPS = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   func_in,
    output logic [WIDTH-1:0]   inject_out,
    input  logic [7:0]         group_sel,
    input  logic [GROUP_W-1:0] inj_mask,
    input  logic [GROUP_W-1:0] inj_value,
`ifdef RTL_INJECT_XOR_EN
    input  logic               inj_xor_mode,
`endif
    input  logic [CNT_W-1:0]   delay_cycles,
    input  logic [CNT_W-1:0]   hold_cycles,
    input  logic               trig_en,
    input  logic               trig_in,
    input  logic               cmd_arm,
    input  logic               cmd_abort,
    output logic [1:0]         state,
    output logic               active,
    output logic               done,
    output logic [CNT_W-1:0]   inject_count
);

    inj_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   count_q;
    logic               done_q;
    logic [1:0]         grp_q;
    logic [GROUP_W-1:0] mask_q, value_q;
    logic [CNT_W-1:0]   delay_q, hold_q;
    logic               trig_en_q;
    logic               xor_sel;
    logic               arm_ok, enter_drive, release_drive;
    logic               unused_sel;

    assign unused_sel = ^group_sel[7:2];

    // Next-state and counter load/decrement; abort wins over everything
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        arm_ok        = 1'b0;
        enter_drive   = 1'b0;
        release_drive = 1'b0;
        if (cmd_abort) begin
            state_d       = ST_IDLE;
            release_drive = (state_q == ST_DRIVE);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_arm) begin
                        state_d = ST_ARMED;
                        arm_ok  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_in || !trig_en_q) begin
                        if (delay_q == '0) begin
                            state_d     = ST_DRIVE;
                            enter_drive = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_q - 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d     = ST_DRIVE;
                        enter_drive = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (hold_q != '0) begin
                        if (cnt_q == '0) begin
                            state_d       = ST_IDLE;
                            release_drive = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (enter_drive)
                cnt_d = (hold_q == '0) ? '0 : hold_q - 1'b1;
        end
    end

    // FSM state, shared delay/hold counter, done pulse and entry count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= release_drive;
            if (enter_drive && (count_q != '1))
                count_q <= count_q + 1'b1;
        end
    end

    // Configuration snapshot taken only on an accepted arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q     <= '0;
            mask_q    <= '0;
            value_q   <= '0;
            delay_q   <= '0;
            hold_q    <= '0;
            trig_en_q <= 1'b0;
`ifdef RTL_INJECT_XOR_EN
            xor_sel   <= 1'b0;
`endif
        end else if (arm_ok) begin
            grp_q     <= group_sel[1:0];
            mask_q    <= inj_mask;
            value_q   <= inj_value;
            delay_q   <= delay_cycles;
            hold_q    <= hold_cycles;
            trig_en_q <= trig_en;
`ifdef RTL_INJECT_XOR_EN
            xor_sel   <= inj_xor_mode;
`endif
        end
    end

`ifndef RTL_INJECT_XOR_EN
    assign xor_sel = 1'b0;
`endif

    assign state        = state_q;
    assign active       = (state_q == ST_DRIVE);
    assign done         = done_q;
    assign inject_count = count_q;

    rtl_inject_mux #(
        .WIDTH  (WIDTH),
        .GROUPS (GROUPS)
    ) u_mux (
        .func_in  (func_in),
        .active   (active),
        .grp      (grp_q),
        .mask     (mask_q),
        .value    (value_q),
        .xor_mode (xor_sel),
        .data_out (inject_out)
    );

endmodule

// File: tb/tb_rtl_signal_inject.sv
// Scoreboard bench for rtl_signal_inject: timestamp-based reference model,
// expected responses queued per cycle and checked by a monitor on negedge.
module tb_rtl_signal_inject;

    localparam int WIDTH = 128;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] func_in = '0;
    logic [WIDTH-1:0] inject_out;
    logic [7:0]       group_sel = '0;
    logic [31:0]      inj_mask = '0;
    logic [31:0]      inj_value = '0;
    logic [CNT_W-1:0] delay_cycles = '0;
    logic [CNT_W-1:0] hold_cycles = '0;
    logic             trig_en = 1'b0;
    logic             trig_in = 1'b0;
    logic             cmd_arm = 1'b0;
    logic             cmd_abort = 1'b0;
    logic [1:0]       state;
    logic             active;
    logic             done;
    logic [CNT_W-1:0] inject_count;
`ifdef RTL_INJECT_XOR_EN
    logic             inj_xor_mode = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    bit force_nib = 0;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [1:0]       st;
        logic             act;
        logic             dn;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rtl_signal_inject #(.WIDTH(WIDTH), .GROUPS(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_in      (func_in),
        .inject_out   (inject_out),
        .group_sel    (group_sel),
        .inj_mask     (inj_mask),
        .inj_value    (inj_value),
`ifdef RTL_INJECT_XOR_EN
        .inj_xor_mode (inj_xor_mode),
`endif
        .delay_cycles (delay_cycles),
        .hold_cycles  (hold_cycles),
        .trig_en      (trig_en),
        .trig_in      (trig_in),
        .cmd_arm      (cmd_arm),
        .cmd_abort    (cmd_abort),
        .state        (state),
        .active       (active),
        .done         (done),
        .inject_count (inject_count)
    );

    // Reference model: a session is described by timestamps, not states
    int          c = 0;
    bit          live = 0, fired = 0, sticky = 0;
    int          from_c = 0, until_c = 0;
    logic [1:0]  m_g = '0;
    logic [31:0] m_mask = '0, m_val = '0;
    int          m_delay = 0, m_hold = 0;
    bit          m_ten = 0, m_xor = 0;
    int          m_cnt = 0;
    bit          m_done = 0;

    function automatic bit drv(int t);
        return live && fired && t >= from_c && (sticky || t < until_c);
    endfunction

    task automatic model_reset();
        live = 0; fired = 0; m_cnt = 0; m_done = 0;
        m_g = '0; m_mask = '0; m_val = '0; m_xor = 0;
    endtask

    task automatic model_edge();
        c++;
        m_done = 0;
        if (cmd_abort) begin
            if (drv(c - 1)) m_done = 1;
            live = 0;
        end else if (!live) begin
            if (cmd_arm) begin
                live = 1; fired = 0;
                m_g = group_sel[1:0];
                m_mask = inj_mask; m_val = inj_value;
                m_delay = int'(delay_cycles);
                m_hold = int'(hold_cycles);
                m_ten = trig_en;
`ifdef RTL_INJECT_XOR_EN
                m_xor = inj_xor_mode;
`else
                m_xor = 0;
`endif
            end
        end else if (!fired) begin
            if (trig_in || !m_ten) begin
                fired = 1;
                from_c = c + m_delay;
                until_c = from_c + m_hold;
                sticky = (m_hold == 0);
            end
        end
        if (live && fired && !sticky && c == until_c) begin
            m_done = 1;
            live = 0;
        end
        if (drv(c) && c == from_c && m_cnt < 65535) m_cnt++;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [WIDTH-1:0] mm, vv;
        if (!live) e.st = 2'd0;
        else if (!fired) e.st = 2'd1;
        else if (c < from_c) e.st = 2'd2;
        else e.st = 2'd3;
        e.act = (e.st == 2'd3);
        e.dn  = m_done;
        e.cnt = CNT_W'(m_cnt);
        mm = WIDTH'(m_mask) << (32 * int'(m_g));
        vv = WIDTH'(m_val) << (32 * int'(m_g));
        if (!e.act) e.out = func_in;
        else if (m_xor) e.out = func_in ^ (vv & mm);
        else e.out = (func_in & ~mm) | (vv & mm);
        return e;
    endfunction

    // One cycle: model the edge, then drive new data and queue expectation
    task automatic step(input bit r = 1);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        rst_n = r;
        if (!r) model_reset();
        func_in = {$urandom, $urandom, $urandom, $urandom};
        if (force_nib) func_in[3:0] = 4'h6;
        cmd_arm = 0;
        cmd_abort = 0;
        trig_in = 0;
        sb.push_back(model_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic setup(input logic [7:0] g, input logic [31:0] m,
                         input logic [31:0] v, input int d, input int h,
                         input bit te);
        group_sel = g; inj_mask = m; inj_value = v;
        delay_cycles = CNT_W'(d); hold_cycles = CNT_W'(h); trig_en = te;
    endtask

    task automatic chk(input string nm, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, a, e);
        end
    endtask

    // Monitor: pop and compare whatever the stimulus queued for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("inject_out", inject_out, e.out);
                chk("state", WIDTH'(state), WIDTH'(e.st));
                chk("active", WIDTH'(active), WIDTH'(e.act));
                chk("done", WIDTH'(done), WIDTH'(e.dn));
                chk("inject_count", WIDTH'(inject_count), WIDTH'(e.cnt));
            end
        end
    end

    initial begin
        int n;
        step(0);
        step(0);
        step(1);
        // Unarmed pass-through
        run(100);
        // Group 1 directed, immediate start, hold 4
        setup(8'd1, 32'h0000_FFFF, 32'h0000_A5A5, 0, 4, 0);
        cmd_arm = 1;
        run(10);
        // Triggered with delay 3, hold 2
        setup(8'd2, 32'hFFFF_0000, 32'h1234_5678, 3, 2, 1);
        cmd_arm = 1;
        run(20);
        trig_in = 1;
        step();
        run(10);
        // Sticky override on group 3, then abort
        setup(8'd3, 32'hFF00_0000, 32'h5A00_0000, 0, 0, 0);
        cmd_arm = 1;
        run(1000);
        cmd_abort = 1;
        run(3);
        // Abort and arm together in IDLE
        cmd_arm = 1; cmd_abort = 1;
        run(3);
        // Arm during DELAY is ignored, original config kept
        setup(8'd2, 32'h00FF_00FF, 32'hCAFE_BABE, 10, 3, 0);
        cmd_arm = 1;
        run(4);
        setup(8'd0, 32'hFFFF_FFFF, 32'h0, 1, 9, 1);
        cmd_arm = 1;
        run(20);
        // Asynchronous reset in the middle of a sticky drive
        setup(8'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0, 0);
        cmd_arm = 1;
        run(5);
        step(0);
        step(0);
        step(1);
        // Empty mask still runs the full sequence
        setup(8'hFE, 32'h0, 32'hFFFF_FFFF, 2, 3, 0);
        cmd_arm = 1;
        run(10);
`ifdef RTL_INJECT_XOR_EN
        setup(8'd0, 32'hF, 32'hF, 0, 3, 0);
        inj_xor_mode = 1;
        force_nib = 1;
        cmd_arm = 1;
        run(6);
        force_nib = 0;
`endif
        // Randomised sessions with stray commands and config churn
        for (int k = 0; k < 40; k++) begin
            setup(8'($urandom), $urandom, $urandom,
                  $urandom_range(0, 6), $urandom_range(0, 6),
                  1'($urandom));
`ifdef RTL_INJECT_XOR_EN
            inj_xor_mode = 1'($urandom);
`endif
            cmd_arm = 1;
            n = $urandom_range(1, 25);
            for (int i = 0; i < n; i++) begin
                step();
                setup(8'($urandom), $urandom, $urandom,
                      $urandom_range(0, 6), $urandom_range(0, 6),
                      1'($urandom));
                trig_in = ($urandom_range(0, 5) == 0);
                cmd_abort = ($urandom_range(0, 39) == 0);
                cmd_arm = ($urandom_range(0, 9) == 0);
            end
            step();
            cmd_abort = 1;
            run(3);
        end
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
